// File: rtl/gray_stream_codec_if.sv
// Stream bundle for the Gray codec: upstream word/mode handshake and downstream result handshake.
interface gray_stream_codec_if #(
  parameter int unsigned WIDTH = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             adj_err;

  // Source/sink side (drives words in, takes results out)
  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, adj_err
  );

  // Codec side
  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, adj_err
  );
endinterface

// File: rtl/gray_stream_codec.sv
// Streaming Gray<->binary converter with a one-deep output register, Gray adjacency
// checking on decode words and a saturating violation counter.
module gray_stream_codec #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_stream_codec_if.slave   bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q;
  logic               err_q;
  logic [WIDTH-1:0]   prev_gray_q;
  logic               prev_vld_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               consume;
  logic [WIDTH-1:0]   dec;
  logic [WIDTH-1:0]   enc;
  logic [WIDTH-1:0]   diff;
  logic               one_hot;
  logic               flag;

  assign bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.adj_err   = err_q;
  assign err_cnt       = cnt_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = bus.out_valid && bus.out_ready;

  // Output register occupancy
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (consume && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Conversion and adjacency check; decode bit i is the XOR of input bits i..MSB
  always_comb begin
    dec = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      dec[i] = ^(bus.in_data >> i);
    end
    enc     = bus.in_data ^ (bus.in_data >> 1);
    diff    = bus.in_data ^ prev_gray_q;
    one_hot = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    flag    = !bus.mode && prev_vld_q && !one_hot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      err_q       <= 1'b0;
      prev_gray_q <= '0;
      prev_vld_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= bus.mode ? enc : dec;
        err_q  <= flag;
        // An encode word breaks the Gray sequence, so the next decode word is not checked
        if (bus.mode) begin
          prev_vld_q <= 1'b0;
        end else begin
          prev_gray_q <= bus.in_data;
          prev_vld_q  <= 1'b1;
        end
      end
      if (clr_cnt) begin
        cnt_q <= '0;
      end else if (accept && flag && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
